// File: rtl/s1c88_pkg.sv
// Shared types for the S1C88 bus interface and prefetch unit.
package s1c88_pkg;

    typedef enum logic [1:0] {
        BS_IDLE      = 2'd0,
        BS_IRQ_READ  = 2'd1,
        BS_MEM_WRITE = 2'd2,
        BS_MEM_READ  = 2'd3
    } bus_status_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } bus_state_e;

    typedef enum logic [1:0] {
        SRC_VEC_LO   = 2'd0,
        SRC_VEC_HI   = 2'd1,
        SRC_DATA     = 2'd2,
        SRC_PREFETCH = 2'd3
    } src_e;

    // Byte address of one half of a vector table entry.
    function automatic logic [7:0] vec_byte_addr(input logic [6:0] idx, input logic hi);
        return {idx, hi};
    endfunction

endpackage

// File: rtl/s1c88_prefetch_queue.sv
// Code-byte FIFO with flush and a registered head; push and pop may coincide at any fill level.
module s1c88_prefetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output logic [7:0]             head_data
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_n;
    logic [AW:0]   cnt_after_pop;
    logic [AW:0]   count_n;
    logic          pop_eff;
    logic          push_eff;

    always_comb begin
        pop_eff       = pop && head_valid;
        cnt_after_pop = count - (AW+1)'(pop_eff);
        push_eff      = push && (cnt_after_pop < (AW+1)'(DEPTH));
        count_n       = cnt_after_pop + (AW+1)'(push_eff);
        rd_n          = rd_ptr + AW'(pop_eff);
    end

    always_ff @(posedge clk) begin
        if (push_eff && !flush)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= 8'h00;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            rd_ptr     <= rd_n;
            wr_ptr     <= wr_ptr + AW'(push_eff);
            count      <= count_n;
            head_valid <= (count_n != '0);
            // A push into an otherwise empty queue bypasses storage straight to the head.
            if (count_n != '0)
                head_data <= (cnt_after_pop == '0) ? push_data : mem[rd_n];
        end
    end

endmodule

// File: rtl/s1c88_bus_unit.sv
// Bus arbiter and prefetcher: vector fetch > data access > opcode prefetch on one 8-bit bus.
//   state   | meaning
//   IDLE    | no bus cycle, bus_status 0, arbitration every clock
//   ADDR    | address/status/write data driven, one clock
//   DATA    | strobe active, 1+WAIT_STATES clocks then until bus_ready
module s1c88_bus_unit #(
    parameter int ADDR_W       = 24,
    parameter int PC_W         = 16,
    parameter int DEPTH        = 4,
    parameter int WAIT_STATES  = 0,
    parameter int RESET_VECTOR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        data_in,
    input  logic              bus_ready,
    output logic [ADDR_W-1:0] address_out,
    output logic [7:0]        data_out,
    output logic [1:0]        bus_status,
    output logic              read,
    output logic              write,
    output logic              sync,
    output logic              iack,
    output logic              q_valid,
    output logic [7:0]        q_data,
    input  logic              q_pop,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_wdata,
    output logic              mem_ack,
    output logic [7:0]        mem_rdata,
    input  logic              exc_req,
    input  logic [6:0]        exc_vector,
    output logic              exc_done
);
    import s1c88_pkg::*;

    localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    bus_state_e             state, state_n;
    src_e                   src, src_n;
    logic [WW-1:0]          wait_cnt;
    logic [PC_W-1:0]        pc, pc_n;
    logic                   rst_vec_pend, vec_active, pf_discard;
    logic [6:0]             vec_idx, idx_n;
    logic [7:0]             vec_lo;
    logic [ADDR_W-1:0]      addr_n;
    logic [$clog2(DEPTH):0] q_count;

    logic last_data, arb, sel_valid;
    logic inflight_pf, inflight_data;
    logic exc_pend, data_pend, pf_elig;
    logic vec_hi_done, pf_done, data_done, take_redirect;
    logic q_push, q_flush;

    always_comb begin
        last_data     = (state == ST_DATA) && (wait_cnt == '0) && bus_ready;
        arb           = (state == ST_IDLE) || last_data;
        inflight_pf   = (state != ST_IDLE) && (src == SRC_PREFETCH);
        inflight_data = (state != ST_IDLE) && (src == SRC_DATA);
        vec_hi_done   = last_data && (src == SRC_VEC_HI);
        pf_done       = last_data && (src == SRC_PREFETCH);
        data_done     = last_data && (src == SRC_DATA);
        exc_pend      = rst_vec_pend || (exc_req && !vec_active && !exc_done);
        data_pend     = mem_req && !inflight_data && !mem_ack;
        pf_elig       = ((int'(q_count) + int'(inflight_pf)) < DEPTH)
                        && !exc_req && !vec_active && !rst_vec_pend;
        // A freshly loaded exception PC always beats a redirect arriving around it.
        take_redirect = redirect && !exc_done && !vec_hi_done;
        q_push        = pf_done && !pf_discard && !take_redirect;
        q_flush       = vec_hi_done || take_redirect;
        idx_n         = rst_vec_pend ? 7'(RESET_VECTOR) : exc_vector;
    end

    always_comb begin
        pc_n = pc;
        if (vec_hi_done)
            pc_n = PC_W'({data_in, vec_lo});
        else if (take_redirect)
            pc_n = redirect_pc;
        else if (pf_done && !pf_discard)
            pc_n = pc + PC_W'(1);
    end

    always_comb begin
        src_n     = src;
        sel_valid = 1'b1;
        if (last_data && (src == SRC_VEC_LO))
            src_n = SRC_VEC_HI;
        else if (exc_pend)
            src_n = SRC_VEC_LO;
        else if (data_pend)
            src_n = SRC_DATA;
        else if (pf_elig)
            src_n = SRC_PREFETCH;
        else
            sel_valid = 1'b0;

        state_n = state;
        case (state)
            ST_IDLE: if (sel_valid) state_n = ST_ADDR;
            ST_ADDR: state_n = ST_DATA;
            ST_DATA: if (last_data) state_n = sel_valid ? ST_ADDR : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        case (src_n)
            SRC_VEC_LO: addr_n = ADDR_W'(vec_byte_addr(idx_n, 1'b0));
            SRC_VEC_HI: addr_n = ADDR_W'(vec_byte_addr(vec_idx, 1'b1));
            SRC_DATA:   addr_n = mem_addr;
            default:    addr_n = ADDR_W'(pc_n);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            src          <= SRC_PREFETCH;
            wait_cnt     <= '0;
            pc           <= '0;
            rst_vec_pend <= 1'b1;
            vec_active   <= 1'b0;
            vec_idx      <= '0;
            vec_lo       <= 8'h00;
            pf_discard   <= 1'b0;
            address_out  <= '1;
            data_out     <= 8'hFF;
            bus_status   <= BS_IDLE;
            read         <= 1'b0;
            write        <= 1'b0;
            sync         <= 1'b0;
            iack         <= 1'b0;
            mem_ack      <= 1'b0;
            mem_rdata    <= 8'h00;
            exc_done     <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            mem_ack  <= data_done;
            exc_done <= vec_hi_done;
            read     <= (state_n == ST_DATA) && (bus_status != BS_MEM_WRITE);
            write    <= (state_n == ST_DATA) && (bus_status == BS_MEM_WRITE);

            if (data_done && (bus_status == BS_MEM_READ))
                mem_rdata <= data_in;
            if (last_data && (src == SRC_VEC_LO))
                vec_lo <= data_in;
            if (vec_hi_done)
                vec_active <= 1'b0;

            if ((state == ST_ADDR) && (state_n == ST_DATA))
                wait_cnt <= WW'(WAIT_STATES);
            else if ((state == ST_DATA) && (wait_cnt != '0))
                wait_cnt <= wait_cnt - WW'(1);

            // The fetch already on the bus carries the old PC; its byte must not reach the queue.
            if (state_n == ST_ADDR)
                pf_discard <= 1'b0;
            else if (take_redirect && inflight_pf)
                pf_discard <= 1'b1;

            if (state_n == ST_ADDR) begin
                src         <= src_n;
                address_out <= addr_n;
                sync        <= (src_n == SRC_PREFETCH);
                iack        <= (src_n == SRC_VEC_LO) || (src_n == SRC_VEC_HI);
                data_out    <= ((src_n == SRC_DATA) && mem_we) ? mem_wdata : 8'hFF;
                case (src_n)
                    SRC_VEC_LO, SRC_VEC_HI: bus_status <= BS_IRQ_READ;
                    SRC_DATA:               bus_status <= mem_we ? BS_MEM_WRITE : BS_MEM_READ;
                    default:                bus_status <= BS_MEM_READ;
                endcase
                if (src_n == SRC_VEC_LO) begin
                    vec_idx      <= idx_n;
                    vec_active   <= 1'b1;
                    rst_vec_pend <= 1'b0;
                end
            end else if (state_n == ST_IDLE) begin
                bus_status <= BS_IDLE;
                sync       <= 1'b0;
                iack       <= 1'b0;
            end
        end
    end

    s1c88_prefetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (q_flush),
        .push       (q_push),
        .push_data  (data_in),
        .pop        (q_pop),
        .count      (q_count),
        .head_valid (q_valid),
        .head_data  (q_data)
    );

endmodule

// File: tb/tb_s1c88_bus_unit.sv
// Directed bench for s1c88_bus_unit: memory model, bus-cycle scoreboard, queue/ack checks.
module tb_s1c88_bus_unit;

    typedef struct packed {
        logic [23:0] addr;
        logic [1:0]  st;
        logic        sync;
        logic        iack;
        logic [3:0]  len;
    } cyc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_in;
    logic        bus_ready = 1'b1;
    logic [23:0] address_out;
    logic [7:0]  data_out;
    logic [1:0]  bus_status;
    logic        read, write, sync, iack;
    logic        q_valid;
    logic [7:0]  q_data;
    logic        q_pop = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [23:0] mem_addr = 24'h0;
    logic [7:0]  mem_wdata = 8'h00;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        exc_req = 1'b0;
    logic [6:0]  exc_vector = 7'd0;
    logic        exc_done;

    logic [7:0] mem [0:65535];
    cyc_t       exp_q[$];
    cyc_t       got_c;
    int         checks = 0;
    int         errors = 0;
    int         run = 0;

    always #5 clk = ~clk;

    // Read data is only meaningful on a clock that can end the DATA phase (WAIT_STATES=2).
    assign data_in = (run >= 3 && bus_ready) ? mem[address_out[15:0]] : 8'hEE;

    s1c88_bus_unit #(
        .ADDR_W(24), .PC_W(16), .DEPTH(4), .WAIT_STATES(2), .RESET_VECTOR(0)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .bus_ready(bus_ready),
        .address_out(address_out), .data_out(data_out), .bus_status(bus_status),
        .read(read), .write(write), .sync(sync), .iack(iack),
        .q_valid(q_valid), .q_data(q_data), .q_pop(q_pop),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .exc_req(exc_req), .exc_vector(exc_vector), .exc_done(exc_done)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic cyc_t cy(logic [23:0] a, logic [1:0] s, logic sy, logic ia, logic [3:0] l);
        return {a, s, sy, ia, l};
    endfunction

    task automatic expect_pf(logic [15:0] pc, int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(cy({8'h00, pc + 16'(i)}, 2'd3, 1'b1, 1'b0, 4'd3));
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic probe(int w);
        case (w)
            0:       return mem_ack;
            1:       return exc_done;
            2:       return read;
            default: return sync && read;
        endcase
    endfunction

    task automatic wait_for(string tag, int w, int max);
        int k = 0;
        while (!probe(w) && k < max) begin
            tick();
            k++;
        end
        chk(tag, 32'(probe(w)), 32'd1);
    endtask

    task automatic wait_sb(string tag, int max);
        int k = 0;
        while (exp_q.size() != 0 && k < max) begin
            tick();
            k++;
        end
        tick(8);
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Bus monitor: one record per completed cycle, compared in order against the scoreboard.
    always @(negedge clk) begin
        if (reset || !(read || write)) begin
            run = 0;
        end else begin
            run = run + 1;
            if (run >= 3 && bus_ready) begin
                got_c = {address_out, bus_status, sync, iack, 4'(run)};
                if (write)
                    mem[address_out[15:0]] = data_out;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_extra: observed cycle %h expected none", got_c);
                end
                if (exp_q.size() != 0)
                    chk("bus_cycle", got_c, exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5C;
        mem[0] = 8'h34; mem[1] = 8'h12;
        mem[6] = 8'hCD; mem[7] = 8'hAB;
        for (int i = 0; i < 16; i++) mem[16'h1234 + i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 4; i++)  mem[16'h8000 + i] = 8'hC0 + 8'(i);
        for (int i = 0; i < 4; i++)  mem[16'hABCD + i] = 8'h50 + 8'(i);
        mem[16'h2000] = 8'h5A; mem[16'h2001] = 8'h77; mem[16'h2002] = 8'h00;
        mem[16'hFFFE] = 8'h61; mem[16'hFFFF] = 8'h62;

        tick(3);
        chk("rst_addr", address_out, 32'hFF_FFFF);
        chk("rst_dout", data_out, 32'hFF);
        chk("rst_bus", {bus_status, read, write, sync, iack}, 0);
        chk("rst_flags", {q_valid, mem_ack, exc_done}, 0);
        chk("rst_rdata", mem_rdata, 0);

        // Reset vector fetch, then fill the queue and stop.
        exp_q.push_back(cy(24'h0, 2'd1, 1'b0, 1'b1, 4'd3));
        exp_q.push_back(cy(24'h1, 2'd1, 1'b0, 1'b1, 4'd3));
        expect_pf(16'h1234, 4);
        reset = 1'b0;
        wait_for("rst_exc_done", 1, 40);
        wait_sb("fill", 60);
        chk("fill_head", {q_valid, q_data}, {1'b1, 8'hA0});
        chk("fill_idle", {bus_status, sync}, 0);

        // One pop frees one slot: single refetch.
        expect_pf(16'h1238, 1);
        q_pop = 1'b1; tick(); q_pop = 1'b0;
        chk("pop_head", q_data, 8'hA1);
        wait_sb("refetch", 40);

        // Data read inserted behind the running prefetch.
        expect_pf(16'h1239, 1);
        exp_q.push_back(cy(24'h002000, 2'd3, 1'b0, 1'b0, 4'd3));
        expect_pf(16'h123A, 1);
        q_pop = 1'b1; tick();
        chk("pop2_head", q_data, 8'hA2);
        tick(); q_pop = 1'b0;
        chk("pop3_head", q_data, 8'hA3);
        wait_for("pf_data_phase", 3, 20);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 24'h002000;
        wait_for("rd_ack", 0, 40);
        chk("rd_rdata", mem_rdata, 8'h5A);
        mem_req = 1'b0;
        tick();
        chk("ack_pulse", mem_ack, 0);
        wait_sb("prio", 40);

        // Wait states plus three clocks of bus_ready low.
        exp_q.push_back(cy(24'h002001, 2'd3, 1'b0, 1'b0, 4'd6));
        mem_req = 1'b1; mem_addr = 24'h002001;
        wait_for("ws_data", 2, 20);
        tick(2); bus_ready = 1'b0;
        tick(3); bus_ready = 1'b1;
        wait_for("ws_ack", 0, 20);
        chk("ws_rdata", mem_rdata, 8'h77);
        mem_req = 1'b0;
        wait_sb("ws", 40);

        // Data write.
        exp_q.push_back(cy(24'h002002, 2'd2, 1'b0, 1'b0, 4'd3));
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 24'h002002; mem_wdata = 8'h3C;
        wait_for("wr_ack", 0, 40);
        mem_req = 1'b0; mem_we = 1'b0;
        chk("wr_mem", mem[16'h2002], 8'h3C);
        wait_sb("wr", 40);

        // Redirect during DATA of an in-flight prefetch.
        expect_pf(16'h123B, 1);
        expect_pf(16'h8000, 4);
        q_pop = 1'b1; tick(); q_pop = 1'b0;
        chk("pop4_head", q_data, 8'hA4);
        wait_for("rdr_pf_data", 3, 20);
        redirect = 1'b1; redirect_pc = 16'h8000;
        tick(); redirect = 1'b0;
        chk("rdr_flush", q_valid, 0);
        wait_sb("redirect", 80);
        chk("rdr_head", {q_valid, q_data}, {1'b1, 8'hC0});

        // Exception with a full queue.
        exp_q.push_back(cy(24'h6, 2'd1, 1'b0, 1'b1, 4'd3));
        exp_q.push_back(cy(24'h7, 2'd1, 1'b0, 1'b1, 4'd3));
        expect_pf(16'hABCD, 4);
        exc_vector = 7'd3; exc_req = 1'b1;
        wait_for("exc_done", 1, 40);
        chk("exc_flush", q_valid, 0);
        exc_req = 1'b0;
        wait_sb("exc", 80);
        chk("exc_head", {q_valid, q_data}, {1'b1, 8'h50});

        // PC wrap through 0xFFFF.
        expect_pf(16'hFFFE, 4);
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick(); redirect = 1'b0;
        wait_sb("wrap", 80);
        chk("wrap_head", {q_valid, q_data}, {1'b1, 8'h61});
        expect_pf(16'h0002, 1);
        q_pop = 1'b1; tick(); q_pop = 1'b0;
        chk("wrap_pop", q_data, 8'h62);
        wait_sb("wrap_refetch", 40);

        // Reset in the middle of a bus cycle.
        q_pop = 1'b1; tick(); q_pop = 1'b0;
        wait_for("pre_rst_data", 2, 20);
        reset = 1'b1;
        #1;
        chk("mid_rst_bus", {address_out, bus_status, read, sync}, {24'hFF_FFFF, 2'd0, 1'b0, 1'b0});
        chk("mid_rst_q", q_valid, 0);
        exp_q.push_back(cy(24'h0, 2'd1, 1'b0, 1'b1, 4'd3));
        exp_q.push_back(cy(24'h1, 2'd1, 1'b0, 1'b1, 4'd3));
        expect_pf(16'h1234, 4);
        tick();
        reset = 1'b0;
        wait_sb("post_reset", 80);
        chk("post_rst_head", {q_valid, q_data}, {1'b1, 8'hA0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
